// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: one request becomes one 65-bit MDC-clocked frame.
// Optional macro MDIO_RDSYNC_EN inserts a 2-FF synchroniser on i_mdio_i.
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [4:0]  i_req_phyad,
    input  logic [4:0]  i_req_regad,
    input  logic [15:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [15:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mdc,
    output logic        o_mdio_o,
    output logic        o_mdio_t,
    input  logic        i_mdio_i
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [6:0] BIT_HDR  = 7'd32;
    localparam logic [6:0] BIT_TA   = 7'd46;
    localparam logic [6:0] BIT_TA2  = 7'd47;
    localparam logic [6:0] BIT_DATA = 7'd48;
    localparam logic [6:0] BIT_END  = 7'd64;

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_END} state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [6:0]       bit_cnt;
    logic [6:0]       bit_next;
    logic [63:0]      tx_sr;
    logic [63:0]      req_frame;
    logic [15:0]      rx_sr;
    logic             wr;
    logic             ta_err;
    logic             mdio_in;

    function automatic state_t phase_of(input logic [6:0] b);
        if (b >= BIT_END)       return ST_END;
        else if (b >= BIT_DATA) return ST_DATA;
        else if (b >= BIT_TA)   return ST_TA;
        else if (b >= BIT_HDR)  return ST_HDR;
        else                    return ST_PRE;
    endfunction

    // Pad is released from TA onward on reads and always during the idle bit.
    function automatic logic released(input logic [6:0] b, input logic is_wr);
        return (b >= BIT_END) || ((b >= BIT_TA) && !is_wr);
    endfunction

`ifdef MDIO_RDSYNC_EN
    logic sync_a, sync_b;
    always_ff @(posedge i_clk) begin
        sync_a <= i_mdio_i;
        sync_b <= sync_a;
    end
    assign mdio_in = sync_b;
`else
    assign mdio_in = i_mdio_i;
`endif

    // Released read bits carry 1s so the idle pad level is driven into o_mdio_o.
    assign req_frame = i_req_write
        ? {32'hFFFF_FFFF, 2'b01, 2'b01, i_req_phyad, i_req_regad, 2'b10, i_req_wdata}
        : {32'hFFFF_FFFF, 2'b01, 2'b10, i_req_phyad, i_req_regad, 2'b11, 16'hFFFF};
    assign bit_next = bit_cnt + 7'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            div          <= '0;
            bit_cnt      <= '0;
            o_mdc        <= 1'b0;
            o_mdio_t     <= 1'b1;
            o_mdio_o     <= 1'b1;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
        end else begin
            o_resp_valid <= 1'b0;
            if (state == ST_IDLE) begin
                o_mdc    <= 1'b0;
                div      <= '0;
                bit_cnt  <= '0;
                o_mdio_t <= 1'b1;
                o_mdio_o <= 1'b1;
                if (i_req_valid) begin
                    wr          <= i_req_write;
                    tx_sr       <= {req_frame[62:0], 1'b1};
                    o_mdio_o    <= req_frame[63];
                    o_mdio_t    <= 1'b0;
                    o_req_ready <= 1'b0;
                    state       <= ST_PRE;
                end
            end else if (div == DIV_LAST) begin
                div <= '0;
                if (!o_mdc) begin
                    o_mdc <= 1'b1;
                end else begin
                    // MDC falling edge: advance to the next bit.
                    o_mdc    <= 1'b0;
                    bit_cnt  <= bit_next;
                    state    <= phase_of(bit_next);
                    o_mdio_o <= tx_sr[63];
                    tx_sr    <= {tx_sr[62:0], 1'b1};
                    o_mdio_t <= released(bit_next, wr);
                    if (!wr && bit_cnt == BIT_TA2) ta_err <= mdio_in;
                    if (!wr && state == ST_DATA)   rx_sr  <= {rx_sr[14:0], mdio_in};
                end
            end else begin
                div <= div + 1'b1;
                // Leave one cycle early so IDLE/ready coincide with the response pulse.
                if (state == ST_END && o_mdc && div == DIV_PRE) begin
                    state        <= ST_IDLE;
                    o_req_ready  <= 1'b1;
                    o_resp_valid <= 1'b1;
                    if (wr) begin
                        o_resp_err <= 1'b0;
                    end else begin
                        o_resp_rdata <= rx_sr;
                        o_resp_err   <= ta_err;
                    end
                end
            end
        end
    end
endmodule
